spi_master_param: RTL and testbench

//  Parametrised SPI master, successor of the fixed 8-bit, single-slave, mode-0 SPI block.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_param_if.sv | 30 +++
 rtl/spi_clk_gen.sv | 43 ++++
 rtl/spi_master_param.sv | 174 +++++++++++++++++
 tb/tb_spi_master_param.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_e;

  // Wide enough for the largest supported chip-select count; sliced per instance.
  localparam int CS_MAX = 8;
  localparam logic [CS_MAX-1:0] CS_IDLE = '1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Control-side handshake bundle between the requesting logic and the SPI master.
interface spi_master_param_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CS   = 1
) ();

  localparam int CS_W = cnt_w(N_CS);

  logic              start;
  logic              cpol;
  logic              cpha;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;

  modport master (
    output start, cpol, cpha, cs_sel, tx_data,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, cpol, cpha, cs_sel, tx_data,
    output rx_data, busy, done
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period divider: tick marks every CLK_DIV-th cycle while enabled; lead/trail strobes during XFER.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic xfer,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             ph_q, ph_d;

  assign tick       = en && (div_q == DIV_W'(CLK_DIV - 1));
  assign lead_edge  = tick && xfer && !ph_q;
  assign trail_edge = tick && xfer && ph_q;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (!en || tick) div_d = '0;
    // Phase restarts at leading for every frame because it is held low outside XFER.
    ph_d = 1'b0;
    if (xfer) ph_d = ph_q ^ tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master (word width, divider, runtime CPOL/CPHA, N chip selects).
// Optional SPI_LSB_FIRST_EN adds a lsb_first input selecting bit order per transfer.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_CS    = 1,
  parameter int CLK_DIV = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_param_if.slave   ctl,
`ifdef SPI_LSB_FIRST_EN
  input  logic                lsb_first,
`endif
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic [N_CS-1:0]     cs_n
);

  localparam int BIT_W = cnt_w(DATA_W);
  localparam logic [N_CS-1:0] CS_ALL = CS_IDLE[N_CS-1:0];

  spi_state_e        state_q, state_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [N_CS-1:0]   cs_n_q, cs_n_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;

  logic lsb_in, accept, tick, lead_edge, trail_edge, drive, sample;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // The done cycle itself never accepts, so back-to-back frames are separated by one idle cycle.
  assign accept = (state_q == IDLE) && !done_q && ctl.start && (32'(ctl.cs_sel) < N_CS);
  assign drive  = cpha_q ? lead_edge : trail_edge;
  assign sample = cpha_q ? trail_edge : lead_edge;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q != IDLE),
    .xfer       (state_q == XFER),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        if (accept) begin
          state_d   = SETUP;
          busy_d    = 1'b1;
          cpol_d    = ctl.cpol;
          cpha_d    = ctl.cpha;
          lsb_d     = lsb_in;
          sclk_d    = ctl.cpol;
          bit_cnt_d = '0;
          cs_n_d    = CS_ALL & ~(N_CS'(1) << ctl.cs_sel);
          // CPHA=0 slaves sample on the first edge, so the first bit must be valid already.
          if (!ctl.cpha) mosi_d = first_bit(ctl.tx_data, lsb_in);
        end
      end
      SETUP: if (tick) state_d = XFER;
      XFER: begin
        if (lead_edge || trail_edge) sclk_d = ~sclk_q;
        if (drive) mosi_d = first_bit(tx_sr_q, lsb_q);
        if (trail_edge) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = CS_ALL;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    if (accept) tx_sr_d = ctl.cpha ? ctl.tx_data : shift_out(ctl.tx_data, lsb_in);
    else if (drive) tx_sr_d = shift_out(tx_sr_q, lsb_q);
    if (sample) rx_sr_d = shift_in(rx_sr_q, miso, lsb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= CS_ALL;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Shift registers are fully rewritten every frame, so they carry no reset.
  always_ff @(posedge clk) begin
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign ctl.rx_data = rx_data_q;
  assign ctl.busy    = busy_q;
  assign ctl.done    = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed plus randomized frames against a behavioural SPI slave and frame-level expectations.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int NCS = 5;
  localparam int DIV = 4;
  localparam int CSW = cnt_w(NCS);
  localparam int LAT = DIV * (2 * DW + 2);
  localparam logic [NCS-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miso, sclk, mosi;
  logic [NCS-1:0] cs_n;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif

  spi_master_param_if #(.DATA_W(DW), .N_CS(NCS)) ctl ();

  spi_master_param #(.DATA_W(DW), .N_CS(NCS), .CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl       (ctl),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural slave: frames delimited by cs_n, edges classified from the configured mode.
  bit          loop_en = 1'b0;
  logic        miso_s;
  bit [DW-1:0] s_word, s_cap;
  bit          f_cpol, f_cpha, f_lsb;

  assign miso = loop_en ? mosi : miso_s;

  function automatic int bidx(input int k);
    return f_lsb ? k : DW - 1 - k;
  endfunction

  initial begin
    int   nb, ko;
    logic last;
    bit   lead;
    miso_s = 1'b0;
    forever begin
      @(cs_n);
      if (cs_n !== ALL1 && !$isunknown(cs_n)) begin
        s_cap = '0;
        nb    = 0;
        ko    = 0;
        last  = f_cpol;
        if (!f_cpha) miso_s = s_word[bidx(0)];
        while (cs_n !== ALL1) begin
          @(sclk or cs_n);
          if (cs_n === ALL1) break;
          if (sclk === last) continue;
          last = sclk;
          lead = (sclk !== f_cpol);
          if (lead != f_cpha) begin
            if (nb < DW) s_cap[bidx(nb)] = mosi;
            nb++;
          end else if (f_cpha) begin
            if (ko < DW) miso_s = s_word[bidx(ko)];
            ko++;
          end else begin
            ko++;
            if (ko < DW) miso_s = s_word[bidx(ko)];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input bit cp, input bit ch, input int cs, input logic [DW-1:0] tx,
                           input logic [DW-1:0] sw, input bit lp, input bit lsb,
                           input int poke, input int rst_at, input bit restart);
    logic [NCS-1:0] exp_cs;
    logic [DW-1:0]  exp_rx;
    int done_at, ndone, tog, d2;
    bit cs_bad;
    logic prev_sclk;
    for (int i = 0; i < NCS; i++) exp_cs[i] = (i != cs);
    exp_rx = lp ? tx : sw;
    @(negedge clk);
    f_cpol = cp; f_cpha = ch; f_lsb = lsb; s_word = sw; loop_en = lp;
    ctl.cpol = cp; ctl.cpha = ch; ctl.cs_sel = CSW'(cs); ctl.tx_data = tx; ctl.start = 1'b1;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    @(posedge clk); #1;
    ctl.start = 1'b0;
    chk("busy_accept", ctl.busy, 1);
    chk("cs_accept", cs_n, exp_cs);
    chk("sclk_accept", sclk, cp);
    done_at = -1; ndone = 0; tog = 0; cs_bad = 1'b0; prev_sclk = sclk;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      if (sclk !== prev_sclk) tog++;
      prev_sclk = sclk;
      if (ctl.done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at < 0 && cs_n !== exp_cs) cs_bad = 1'b1;
      if (poke > 0) begin
        ctl.start = (c == poke);
        if (c == poke) begin
          ctl.tx_data = ~tx;
          ctl.cs_sel  = CSW'((cs + 1) % NCS);
        end
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cs", cs_n, ALL1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", ctl.busy, 0);
        chk("rst_done", ctl.done, 0);
        chk("rst_rx", ctl.rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (restart && c == LAT) ctl.start = 1'b1;
    end
    chk("latency", done_at, LAT);
    chk("done_count", ndone, 1);
    chk("cs_frame", cs_bad, 0);
    chk("sclk_toggles", tog, 2 * DW);
    chk("rx_data", ctl.rx_data, exp_rx);
    chk("mosi_word", s_cap, tx);
    chk("busy_end", ctl.busy, 0);
    chk("cs_end", cs_n, ALL1);
    chk("sclk_idle", sclk, cp);
    if (restart) begin
      @(posedge clk); #1;
      ctl.start = 1'b0;
      chk("restart_accept", ctl.busy, 1);
      d2 = -1;
      for (int c = 1; c <= LAT + 1; c++) begin
        @(posedge clk); #1;
        if (ctl.done === 1'b1 && d2 < 0) d2 = c;
      end
      chk("restart_latency", d2, LAT);
      chk("restart_rx", ctl.rx_data, exp_rx);
    end
  endtask

  initial begin
    bit rl;
    ctl.start = 1'b0; ctl.cpol = 1'b0; ctl.cpha = 1'b0; ctl.cs_sel = '0; ctl.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_cs", cs_n, ALL1);
    chk("reset_rx", ctl.rx_data, 0);
    chk("reset_busy", ctl.busy, 0);
    chk("reset_done", ctl.done, 0);
    rst_n = 1'b1;

    run_frame(0, 0, 0, 8'hAA, 8'hFF, 0, 0, 0, 0, 0);
    run_frame(1, 1, 1, 8'h5A, DW'($urandom), 1, 0, 0, 0, 0);
    run_frame(1'($urandom), 1'($urandom), 2, DW'($urandom), DW'($urandom), 0, 0, 0, 0, 0);

    for (int s = NCS; s < (1 << CSW); s++) begin
      @(negedge clk);
      ctl.cs_sel = CSW'(s); ctl.start = 1'b1;
      @(posedge clk); #1;
      ctl.start = 1'b0;
      chk("bad_cs_busy", ctl.busy, 0);
      @(posedge clk); #1;
      chk("bad_cs_lines", cs_n, ALL1);
    end

    run_frame(0, 1, 3, DW'($urandom), DW'($urandom), 0, 0, 30, 0, 0);
    run_frame(1, 0, 4, DW'($urandom), DW'($urandom) | 8'h81, 0, 0, 0, 0, 1);
    run_frame(1, 0, 0, DW'($urandom), 8'hC3, 0, 0, 0, DIV + 6 * DIV + 1, 0);
    run_frame(0, 0, 2, DW'($urandom), DW'($urandom), 0, 0, 0, 0, 0);
`ifdef SPI_LSB_FIRST_EN
    run_frame(0, 0, 0, 8'h01, 8'h00, 1, 1, 0, 0, 0);
    run_frame(1, 1, 1, DW'($urandom), DW'($urandom), 0, 1, 0, 0, 0);
`endif
    for (int i = 0; i < 10; i++) begin
`ifdef SPI_LSB_FIRST_EN
      rl = 1'($urandom);
`else
      rl = 1'b0;
`endif
      run_frame(1'($urandom), 1'($urandom), int'($urandom_range(NCS - 1, 0)),
                DW'($urandom), DW'($urandom), 1'($urandom), rl, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
